// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter and its rotating picker.
package arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int ID_W      = 2;
  localparam int HOLD_W    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ_DEF-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return N_REQ_DEF'(1) << id;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating first-set search: rotates req so ptr lands on bit 0, priority-encodes
// the rotated vector, then rotates the resulting offset back into an absolute index.
module rr_priority_pick
  import arb_pkg::*;
(
  input  logic [3:0]      req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic [3:0]      rot;
  logic [ID_W-1:0] off;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      logic [ID_W-1:0] src;
      assign src     = ID_W'(gi) + ptr;
      assign rot[gi] = req[src];
    end
  endgenerate

  always_comb begin
    off = '0;
    casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
  end

  assign any = |req;
  assign idx = off + ptr;

endmodule

// File: rtl/rr_arbiter.sv
// Four-way round-robin arbiter with an ownership time limit; every output is a flop,
// and each release inserts one idle cycle before the next grant.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state_reg, state_next;
  logic [N_REQ-1:0]  gnt_reg, gnt_next;
  logic [ID_W-1:0]   gnt_id_reg, gnt_id_next;
  logic              gnt_valid_reg, gnt_valid_next;
  logic              preempt_reg, preempt_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;

  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic              owner_req;
  logic              others_req;

  rr_priority_pick u_pick (
    .req (req),
    .ptr (ptr_reg),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign owner_req  = req[gnt_id_reg];
  assign others_req = |(req & ~gnt_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      gnt_id_reg    <= '0;
      gnt_valid_reg <= 1'b0;
      preempt_reg   <= 1'b0;
      hold_cnt_reg  <= '0;
      ptr_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      gnt_id_reg    <= gnt_id_next;
      gnt_valid_reg <= gnt_valid_next;
      preempt_reg   <= preempt_next;
      hold_cnt_reg  <= hold_cnt_next;
      ptr_reg       <= ptr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    gnt_id_next    = gnt_id_reg;
    gnt_valid_next = gnt_valid_reg;
    preempt_next   = 1'b0;
    hold_cnt_next  = hold_cnt_reg;
    ptr_next       = ptr_reg;

    unique case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next     = BUSY;
          gnt_next       = id_to_onehot(pick_idx);
          gnt_id_next    = pick_idx;
          gnt_valid_next = 1'b1;
          hold_cnt_next  = '0;
        end
      end
      BUSY: begin
        // An owner that drops its request releases normally even at the time limit.
        if (!owner_req || (hold_cnt_reg == HOLD_LAST && others_req)) begin
          state_next     = IDLE;
          gnt_next       = '0;
          gnt_id_next    = '0;
          gnt_valid_next = 1'b0;
          hold_cnt_next  = '0;
          ptr_next       = gnt_id_reg + ID_W'(1);
          preempt_next   = owner_req;
        end else if (hold_cnt_reg != HOLD_LAST) begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign gnt       = gnt_reg;
  assign gnt_id    = gnt_id_reg;
  assign gnt_valid = gnt_valid_reg;
  assign preempt   = preempt_reg;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: a vector table for grant/release/reset behaviour,
// then hand-written sequences for timeout preemption and the drop-at-limit case.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  rr_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       valid;
    logic       preempt;
  } vec_t;

  vec_t vecs[31];

  task automatic step(input logic r, input logic [3:0] q);
    rst_n = r;
    req   = q;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid,
                       input logic ev, input logic ep);
    checks++;
    if (gnt !== eg || gnt_id !== eid || gnt_valid !== ev || preempt !== ep) begin
      errors++;
      $display("FAIL %s: got gnt=%b id=%0d valid=%b preempt=%b, want gnt=%b id=%0d valid=%b preempt=%b",
               name, gnt, gnt_id, gnt_valid, preempt, eg, eid, ev, ep);
    end else begin
      $display("ok   %s: req=%b gnt=%b id=%0d valid=%b preempt=%b",
               name, req, gnt, gnt_id, gnt_valid, preempt);
    end
  endtask

  function automatic logic [3:0] oh(input logic [1:0] id);
    logic [3:0] one;
    one = 4'b0001;
    return one << id;
  endfunction

  initial begin
    // {rst_n, req, expected gnt, gnt_id, valid, preempt} after the next edge
    vecs[0]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[22] = '{1'b1, 4'b1101, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[24] = '{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[25] = '{1'b1, 4'b1011, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[26] = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[27] = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[28] = '{1'b1, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[29] = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[30] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 31; i++) begin
      step(vecs[i].rst_n, vecs[i].req);
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].gnt_id, vecs[i].valid, vecs[i].preempt);
    end

    // Lone owner past the time limit keeps the grant; a late arrival forces a preempt.
    step(1'b0, 4'b0000);
    check("hold_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 4'b0001);
      check($sformatf("hold_lone%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step(1'b1, 4'b0011);
    check("hold_preempt", 4'b0000, 2'd0, 1'b0, 1'b1);
    step(1'b1, 4'b0011);
    check("hold_next", 4'b0010, 2'd1, 1'b1, 1'b0);

    // All requesting continuously: 8-cycle tenures, preempt idle between, order 1,2,3,0.
    for (int k = 0; k < 4; k++) begin
      logic [1:0] owner;
      owner = 2'((1 + k) % 4);
      for (int c = (k == 0) ? 1 : 0; c < 8; c++) begin
        step(1'b1, 4'b1111);
        check($sformatf("rot%0d_c%0d", k, c), oh(owner), owner, 1'b1, 1'b0);
      end
      step(1'b1, 4'b1111);
      check($sformatf("rot%0d_pre", k), 4'b0000, 2'd0, 1'b0, 1'b1);
    end

    // Owner drops on the very cycle the limit is reached: plain release, no preempt.
    step(1'b0, 4'b0000);
    check("drop_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b1, 4'b0100);
    check("drop_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int c = 1; c < 8; c++) begin
      step(1'b1, 4'b0100);
      check($sformatf("drop_hold%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    step(1'b1, 4'b1000);
    check("drop_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b1, 4'b1000);
    check("drop_next", 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b1, 4'b0000);
    check("drop_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters (fixed at 4 in this release).
REQ-002 SHALL have parameter MAX_HOLD, default 8, meaning maximum cycles one owner keeps the grant while other requesters wait (legal range 2..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req  input  4  per-requester request; bit i held high for the whole time requester i wants the resource.
REQ-006 SHALL have port gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-007 SHALL have port gnt_id  output  2  binary index of current owner, registered; 0 when gnt_valid=0.
REQ-008 SHALL have port gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-009 SHALL have port preempt  output  1  one-cycle pulse, registered, on the cycle after a forced timeout release.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no owner) and BUSY (one owner).
REQ-011 In IDLE with req != 0, SHALL select the first set bit of req searching upward from ptr with wrap-around (ptr, ptr+1, ... mod 4); next cycle state=BUSY, gnt=one-hot(winner), gnt_id=winner, hold_cnt=0.
REQ-012 Grant latency SHALL be exactly 1 cycle from req sampled high in IDLE to gnt high.
REQ-013 In IDLE with req == 0, SHALL remain in IDLE with outputs zero and ptr unchanged.
REQ-014 In BUSY, hold_cnt SHALL increment each cycle and saturate at MAX_HOLD-1.
REQ-015 In BUSY, if req[gnt_id]=0, SHALL release: next cycle state=IDLE, gnt=0, ptr=(gnt_id+1) mod 4.
REQ-016 In BUSY, if req[gnt_id]=1, hold_cnt==MAX_HOLD-1, and any other req bit is set, SHALL force release as in REQ-015 and assert preempt for the following cycle.
REQ-017 In BUSY at hold_cnt==MAX_HOLD-1 with no other requester pending, SHALL keep the grant with no preempt; a later arrival of another request SHALL trigger REQ-016 on the cycle it is sampled.
REQ-018 Every release SHALL produce exactly one IDLE cycle (gnt=0) before the next grant; no back-to-back grant.
REQ-019 If the owner drops req on the same cycle the timeout condition holds, SHALL treat it as a normal release (preempt=0).
REQ-020 Requests from non-owners SHALL never change gnt while in BUSY, except via REQ-016.
REQ-021 gnt SHALL never have more than one bit set; gnt_valid SHALL equal (state==BUSY).
REQ-022 Fairness: with all four requesters continuously requesting, grants SHALL rotate 0,1,2,3,0,...; no requester waits more than 3 full ownerships.

Reset
REQ-023 While rst_n=0 at a clock edge, SHALL set state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, preempt=0, hold_cnt=0, ptr=0.
REQ-024 Reset asserted mid-ownership SHALL drop the grant on the next edge with no preempt pulse; first grant after reset release SHALL follow REQ-011 with ptr=0.
REQ-025 req SHALL be ignored during reset; arbitration starts on the first edge with rst_n=1.

Structure
REQ-026 Shared package arb_pkg SHALL hold N_REQ default, the FSM state type (IDLE, BUSY), and the id width constant (2).
REQ-027 Rotating search SHALL live in one combinational sub-module rr_priority_pick (inputs req[3:0], ptr[1:0]; outputs idx[1:0], any); it is the rotated form of the team's 4-to-2 priority encoder.
REQ-028 All outputs SHALL be driven directly from flops; no combinational path from req to any output.

Verification
REQ-029 Reset then req=0000 for 5 cycles -> gnt=0000, gnt_valid=0, preempt=0 every cycle.
REQ-030 After reset, req=0110 -> next cycle gnt=0010, gnt_id=1; drop req[1] -> next cycle gnt=0000; following cycle gnt=0100, gnt_id=2.
REQ-031 req=1111 held, owners drop/raise req to release every 3 cycles -> grant order 0,1,2,3,0, one idle cycle between each.
REQ-032 MAX_HOLD=8, req=0001 alone for 12 cycles -> gnt=0001 throughout, preempt=0; then req=0011 -> next cycle gnt=0000 with preempt=1, following cycle gnt=0010.
REQ-033 Owner 2 drops req on the same cycle hold_cnt reaches 7 with req[3]=1 -> gnt=0000, preempt=0, then gnt=1000.
REQ-034 rst_n=0 for one cycle while gnt=0100 -> next cycle all outputs zero; after release req=0100 -> gnt=0100 one cycle later (ptr=0 search).
